// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, r0 hardwired to zero,
// optional write-through bypass and a per-register busy scoreboard driving the decode stall.
module reg_file_sb #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter bit          BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic              ren1,
   input  logic              ren2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic [ADDR_W-1:0] a3,
   input  logic              we3,
   input  logic [WIDTH-1:0]  wd3,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_dst,
   output logic              busy1,
   output logic              busy2,
   output logic              stall
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   logic w_wr_ok;
   logic w_byp1;
   logic w_byp2;
   logic w_waw;
   logic w_iss_fire;

   assign w_wr_ok = we3 && (a3 != '0);
   assign w_byp1  = BYPASS && we3 && (a3 == a1);
   assign w_byp2  = BYPASS && we3 && (a3 == a2);

   // Read ports: r0 reads zero, bypass takes priority over the stored value
   assign rd1 = (a1 == '0) ? '0 : (w_byp1 ? wd3 : r_regs[a1]);
   assign rd2 = (a2 == '0) ? '0 : (w_byp2 ? wd3 : r_regs[a2]);

   assign busy1 = r_busy[a1] && (a1 != '0) && !w_byp1;
   assign busy2 = r_busy[a2] && (a2 != '0) && !w_byp2;

   // A writeback to the issuing destination in the same cycle resolves the WAW hazard
   assign w_waw = iss_valid && r_busy[iss_dst] && (iss_dst != '0)
                  && !(we3 && (a3 == iss_dst));

   assign stall      = (ren1 && busy1) || (ren2 && busy2) || w_waw;
   assign w_iss_fire = iss_valid && !stall && !reset;

   // Clear from writeback first, then set from issue so a same-register set wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok)
         w_busy_nxt[a3] = 1'b0;
      if (w_iss_fire && (iss_dst != '0))
         w_busy_nxt[iss_dst] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_wr_ok) begin
         r_regs[a3] <= wd3;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_sb;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] a1, a2, a3, iss_dst;
   logic              ren1, ren2, we3, iss_valid;
   logic [WIDTH-1:0]  wd3;

   logic [WIDTH-1:0]  rd1_b, rd2_b, rd1_n, rd2_n;
   logic              busy1_b, busy2_b, stall_b;
   logic              busy1_n, busy2_n, stall_n;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .ren1(ren1), .ren2(ren2),
      .rd1(rd1_b), .rd2(rd2_b), .a3(a3), .we3(we3), .wd3(wd3),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .busy1(busy1_b), .busy2(busy2_b), .stall(stall_b)
   );

   reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dut_nob (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .ren1(ren1), .ren2(ren2),
      .rd1(rd1_n), .rd2(rd2_n), .a3(a3), .we3(we3), .wd3(wd3),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .busy1(busy1_n), .busy2(busy2_n), .stall(stall_n)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; a1 = '0; a2 = '0; a3 = '0; iss_dst = '0;
      ren1 = 1'b0; ren2 = 1'b0; we3 = 1'b0; iss_valid = 1'b0; wd3 = '0;
      tick(); tick();
      reset = 1'b0; a1 = 5'd5; a2 = 5'd9; ren1 = 1'b1; ren2 = 1'b1;
      settle();
      check("rst_rd1", rd1_b, 32'd0);
      check("rst_rd2", rd2_b, 32'd0);
      check("rst_busy1", {31'd0, busy1_b}, 32'd0);
      check("rst_busy2", {31'd0, busy2_b}, 32'd0);
      check("rst_stall", {31'd0, stall_b}, 32'd0);

      // Write 18 to r5; bypass visible only on the bypassing instance
      we3 = 1'b1; a3 = 5'd5; wd3 = 32'd18;
      settle();
      check("byp_rd1_wr_cycle", rd1_b, 32'd18);
      check("nob_rd1_wr_cycle", rd1_n, 32'd0);
      tick();
      we3 = 1'b0;
      settle();
      check("r5_rd1", rd1_b, 32'd18);
      check("r5_rd1_nob", rd1_n, 32'd18);
      a1 = 5'd15;
      settle();
      check("r15_rd1", rd1_b, 32'd0);

      // r0 is hardwired to zero, including under bypass
      we3 = 1'b1; a3 = 5'd0; wd3 = 32'd9; a1 = 5'd0;
      settle();
      check("r0_byp_rd1", rd1_b, 32'd0);
      tick();
      we3 = 1'b0;
      settle();
      check("r0_rd1", rd1_b, 32'd0);
      iss_valid = 1'b1; iss_dst = 5'd0;
      settle();
      check("iss0_stall", {31'd0, stall_b}, 32'd0);
      tick();
      iss_valid = 1'b0; a2 = 5'd0;
      settle();
      check("iss0_busy1", {31'd0, busy1_b}, 32'd0);
      check("iss0_stall_after", {31'd0, stall_b}, 32'd0);

      // RAW on r7 resolved by writeback
      ren1 = 1'b0; ren2 = 1'b0;
      iss_valid = 1'b1; iss_dst = 5'd7;
      settle();
      check("iss7_stall", {31'd0, stall_b}, 32'd0);
      tick();
      iss_valid = 1'b0; ren2 = 1'b1; a2 = 5'd7;
      settle();
      check("raw7_busy2", {31'd0, busy2_b}, 32'd1);
      check("raw7_stall", {31'd0, stall_b}, 32'd1);
      we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234;
      settle();
      check("wb7_byp_busy2", {31'd0, busy2_b}, 32'd0);
      check("wb7_byp_stall", {31'd0, stall_b}, 32'd0);
      check("wb7_byp_rd2", rd2_b, 32'h1234);
      check("wb7_nob_busy2", {31'd0, busy2_n}, 32'd1);
      check("wb7_nob_stall", {31'd0, stall_n}, 32'd1);
      tick();
      we3 = 1'b0;
      settle();
      check("wb7_nob_busy2_next", {31'd0, busy2_n}, 32'd0);
      check("wb7_nob_rd2_next", rd2_n, 32'h1234);
      ren2 = 1'b0;

      // WAW on r3: stalls alone, fires when writeback to r3 coincides (set wins)
      iss_valid = 1'b1; iss_dst = 5'd3;
      tick();
      settle();
      check("waw3_stall", {31'd0, stall_b}, 32'd1);
      tick();
      iss_valid = 1'b0; a1 = 5'd3;
      settle();
      check("waw3_busy1", {31'd0, busy1_n}, 32'd1);
      check("waw3_rd1", rd1_n, 32'd0);
      iss_valid = 1'b1; iss_dst = 5'd3; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h33;
      settle();
      check("waw3_wb_stall", {31'd0, stall_b}, 32'd0);
      tick();
      iss_valid = 1'b0; we3 = 1'b0;
      settle();
      check("setwins_rd1", rd1_n, 32'h33);
      check("setwins_busy1", {31'd0, busy1_n}, 32'd1);
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'h44;
      tick();
      we3 = 1'b0;
      settle();
      check("r3_clear_busy1", {31'd0, busy1_n}, 32'd0);
      check("r3_clear_rd1", rd1_n, 32'h44);

      // Independent set (r13) and clear (r12) in one cycle
      iss_valid = 1'b1; iss_dst = 5'd12;
      tick();
      iss_dst = 5'd13; we3 = 1'b1; a3 = 5'd12; wd3 = 32'hC;
      tick();
      iss_valid = 1'b0; we3 = 1'b0; a1 = 5'd12; a2 = 5'd13;
      settle();
      check("indep_busy1", {31'd0, busy1_b}, 32'd0);
      check("indep_rd1", rd1_b, 32'hC);
      check("indep_busy2", {31'd0, busy2_b}, 32'd1);

      // Reset mid-operation drops busy bits and ignores same-cycle write/issue
      iss_valid = 1'b1; iss_dst = 5'd4;
      tick();
      iss_dst = 5'd9;
      tick();
      iss_valid = 1'b0; a1 = 5'd4; a2 = 5'd9;
      settle();
      check("pre_rst_busy1", {31'd0, busy1_b}, 32'd1);
      check("pre_rst_busy2", {31'd0, busy2_b}, 32'd1);
      reset = 1'b1; we3 = 1'b1; a3 = 5'd5; wd3 = 32'd77; iss_valid = 1'b1; iss_dst = 5'd6;
      tick();
      reset = 1'b0; we3 = 1'b0; iss_valid = 1'b0; ren1 = 1'b1; ren2 = 1'b1;
      settle();
      check("mid_rst_busy1", {31'd0, busy1_b}, 32'd0);
      check("mid_rst_busy2", {31'd0, busy2_b}, 32'd0);
      check("mid_rst_stall", {31'd0, stall_b}, 32'd0);
      a1 = 5'd5; a2 = 5'd6;
      settle();
      check("mid_rst_r5", rd1_b, 32'd0);
      check("mid_rst_busy6", {31'd0, busy2_b}, 32'd0);
      a2 = 5'd7;
      settle();
      check("mid_rst_r7", rd2_b, 32'd0);
      we3 = 1'b1; a3 = 5'd4; wd3 = 32'd5;
      tick();
      we3 = 1'b0; a1 = 5'd4;
      settle();
      check("post_rst_r4", rd1_b, 32'd5);
      check("post_rst_busy1", {31'd0, busy1_b}, 32'd0);

      // All-ones to r31 on both ports, then back-to-back writes
      we3 = 1'b1; a3 = 5'd31; wd3 = 32'hFFFF_FFFF;
      tick();
      we3 = 1'b0; a1 = 5'd31; a2 = 5'd31;
      settle();
      check("r31_ones_rd1", rd1_n, 32'hFFFF_FFFF);
      check("r31_ones_rd2", rd2_n, 32'hFFFF_FFFF);
      we3 = 1'b1; wd3 = 32'd1;
      tick();
      wd3 = 32'd2;
      settle();
      check("b2b_first_nob", rd1_n, 32'd1);
      check("b2b_first_byp", rd1_b, 32'd2);
      check("b2b_stall", {31'd0, stall_b}, 32'd0);
      tick();
      we3 = 1'b0;
      settle();
      check("b2b_second", rd1_n, 32'd2);
      check("b2b_stall_nob", {31'd0, stall_n}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
